// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl
// Purpose  : M-stage load/store sequencer driving a single-beat req/ack bus
//            with alignment exceptions and a WAIT-state timeout.
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [5:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_rdata,
    output logic [1:0]  ld_addr10,
    output logic [5:0]  ld_type,
    output logic        stall,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err
);

    localparam logic [5:0] c_op_lw = 6'b100011;
    localparam logic [5:0] c_op_lh = 6'b100001;
    localparam logic [5:0] c_op_lb = 6'b100000;
    localparam logic [5:0] c_op_sw = 6'b101011;
    localparam logic [5:0] c_op_sh = 6'b101001;
    localparam logic [5:0] c_op_sb = 6'b101000;
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_byteen;
    logic [31:0] r_bus_wdata;
    logic        r_ld_valid;
    logic [31:0] r_ld_rdata;
    logic [1:0]  r_ld_addr10;
    logic [5:0]  r_ld_type;
    logic        r_bus_err;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_aligned;
    logic        w_accept;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_aligned  = 1'b1;
        w_byteen   = 4'b1111;
        w_wdata    = 32'd0;
        case (m_op)
            c_op_lw: begin
                w_is_load = 1'b1;
                w_aligned = (m_addr[1:0] == 2'b00);
            end
            c_op_lh: begin
                w_is_load = 1'b1;
                w_aligned = ~m_addr[0];
            end
            c_op_lb: w_is_load = 1'b1;
            c_op_sw: begin
                w_is_store = 1'b1;
                w_aligned  = (m_addr[1:0] == 2'b00);
                w_wdata    = m_wdata;
            end
            c_op_sh: begin
                w_is_store = 1'b1;
                w_aligned  = ~m_addr[0];
                w_byteen   = m_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{m_wdata[15:0]}};
            end
            c_op_sb: begin
                w_is_store = 1'b1;
                w_byteen   = 4'b0001 << m_addr[1:0];
                w_wdata    = {4{m_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && m_valid && (w_is_load || w_is_store) && w_aligned;

    // Exceptions and stall are combinational so the pipeline sees them in the same cycle.
    assign stall    = w_accept || (r_state == S_WAIT);
    assign exc_adel = (r_state == S_IDLE) && m_valid && w_is_load  && !w_aligned;
    assign exc_ades = (r_state == S_IDLE) && m_valid && w_is_store && !w_aligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_byteen <= 4'b0000;
            r_bus_wdata  <= 32'd0;
            r_ld_valid   <= 1'b0;
            r_ld_rdata   <= 32'd0;
            r_ld_addr10  <= 2'b00;
            r_ld_type    <= 6'b000000;
            r_bus_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_WAIT;
                        r_cnt        <= 8'd0;
                        r_bus_req    <= 1'b1;
                        r_bus_we     <= w_is_store;
                        r_bus_addr   <= {m_addr[31:2], 2'b00};
                        r_bus_byteen <= w_byteen;
                        r_bus_wdata  <= w_wdata;
                        r_ld_addr10  <= m_addr[1:0];
                        r_ld_type    <= m_op;
                    end
                end
                S_WAIT: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (bus_ack) begin
                        r_state    <= S_RESP;
                        r_bus_req  <= 1'b0;
                        r_bus_we   <= 1'b0;
                        if (!r_bus_we) begin
                            r_ld_rdata <= bus_rdata;
                            r_ld_valid <= 1'b1;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        r_state    <= S_RESP;
                        r_bus_req  <= 1'b0;
                        r_bus_we   <= 1'b0;
                        r_ld_rdata <= 32'd0;
                        r_ld_valid <= 1'b0;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_ld_valid <= 1'b0;
                    r_bus_err  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_byteen = r_bus_byteen;
    assign bus_wdata  = r_bus_wdata;
    assign ld_valid   = r_ld_valid;
    assign ld_rdata   = r_ld_rdata;
    assign ld_addr10  = r_ld_addr10;
    assign ld_type    = r_ld_type;
    assign bus_err    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_ctrl
// Purpose  : Directed vector table plus multi-cycle sequences for mem_bus_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam logic [5:0] c_lw = 6'b100011;
    localparam logic [5:0] c_lh = 6'b100001;
    localparam logic [5:0] c_lb = 6'b100000;
    localparam logic [5:0] c_sw = 6'b101011;
    localparam logic [5:0] c_sh = 6'b101001;
    localparam logic [5:0] c_sb = 6'b101000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [5:0]  m_op;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        ld_valid;
    logic [31:0] ld_rdata;
    logic [1:0]  ld_addr10;
    logic [5:0]  ld_type;
    logic        stall;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_op       (m_op),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .ld_valid   (ld_valid),
        .ld_rdata   (ld_rdata),
        .ld_addr10  (ld_addr10),
        .ld_type    (ld_type),
        .stall      (stall),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_adel;
        logic        e_ades;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic        e_ldv;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input int d, input logic [31:0] rd,
                                input logic st, input logic adel, input logic ades, input logic we,
                                input logic [3:0] be, input logic [31:0] ba, input logic [31:0] bw,
                                input logic ldv);
        vec_t r;
        r.valid = v; r.op = op; r.addr = a; r.wdata = wd; r.dly = d; r.rdata = rd;
        r.e_stall = st; r.e_adel = adel; r.e_ades = ades; r.e_we = we; r.e_be = be;
        r.e_baddr = ba; r.e_bwdata = bw; r.e_ldv = ldv;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        m_valid = v.valid; m_op = v.op; m_addr = v.addr; m_wdata = v.wdata;
        #1;
        chk($sformatf("v%0d stall", idx), 32'(stall), 32'(v.e_stall));
        chk($sformatf("v%0d exc_adel", idx), 32'(exc_adel), 32'(v.e_adel));
        chk($sformatf("v%0d exc_ades", idx), 32'(exc_ades), 32'(v.e_ades));
        @(posedge clk); #1;
        m_valid = 1'b0;
        if (v.e_stall) begin
            chk($sformatf("v%0d bus_req", idx), 32'(bus_req), 32'd1);
            chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.e_we));
            chk($sformatf("v%0d bus_addr", idx), bus_addr, v.e_baddr);
            chk($sformatf("v%0d bus_byteen", idx), 32'(bus_byteen), 32'(v.e_be));
            chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.e_bwdata);
            chk($sformatf("v%0d ld_addr10", idx), 32'(ld_addr10), 32'(v.addr[1:0]));
            chk($sformatf("v%0d ld_type", idx), 32'(ld_type), 32'(v.op));
            for (int d = 0; d < v.dly; d++) begin
                @(posedge clk); #1;
            end
            chk($sformatf("v%0d wait req held", idx), 32'(bus_req), 32'd1);
            chk($sformatf("v%0d wait addr held", idx), bus_addr, v.e_baddr);
            chk($sformatf("v%0d wait stall", idx), 32'(stall), 32'd1);
            @(negedge clk);
            bus_ack = 1'b1; bus_rdata = v.rdata;
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
            chk($sformatf("v%0d resp req", idx), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d resp stall", idx), 32'(stall), 32'd0);
            chk($sformatf("v%0d resp ld_valid", idx), 32'(ld_valid), 32'(v.e_ldv));
            chk($sformatf("v%0d resp bus_err", idx), 32'(bus_err), 32'd0);
            if (v.e_ldv) chk($sformatf("v%0d ld_rdata", idx), ld_rdata, v.rdata);
            @(posedge clk); #1;
            chk($sformatf("v%0d ld_valid pulse end", idx), 32'(ld_valid), 32'd0);
        end else begin
            chk($sformatf("v%0d no bus_req", idx), 32'(bus_req), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b0; m_valid = 1'b0; m_op = 6'd0; m_addr = 32'd0; m_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;

        vt[0]  = mk(1, c_lb, 32'h13, 32'h0, 2, 32'hA1B2C3D4, 1, 0, 0, 0, 4'b1111, 32'h10, 32'h0, 1);
        vt[1]  = mk(1, c_sh, 32'h22, 32'h0000BEEF, 0, 32'h0, 1, 0, 0, 1, 4'b1100, 32'h20, 32'hBEEFBEEF, 0);
        vt[2]  = mk(1, c_lw, 32'h06, 32'h0, 0, 32'h0, 0, 1, 0, 0, 4'b0, 32'h0, 32'h0, 0);
        vt[3]  = mk(1, c_sh, 32'h03, 32'h0, 0, 32'h0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h0, 0);
        vt[4]  = mk(1, c_sw, 32'h08, 32'h12345678, 1, 32'h0, 1, 0, 0, 1, 4'b1111, 32'h08, 32'h12345678, 0);
        vt[5]  = mk(1, c_lh, 32'h1E, 32'hFFFFFFFF, 0, 32'h55AA00FF, 1, 0, 0, 0, 4'b1111, 32'h1C, 32'h0, 1);
        vt[6]  = mk(1, c_sb, 32'h02, 32'hABCDEFC3, 0, 32'h0, 1, 0, 0, 1, 4'b0100, 32'h00, 32'hC3C3C3C3, 0);
        vt[7]  = mk(1, 6'b000000, 32'h05, 32'h0, 0, 32'h0, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 0);
        vt[8]  = mk(1, c_lh, 32'h01, 32'h0, 0, 32'h0, 0, 1, 0, 0, 4'b0, 32'h0, 32'h0, 0);
        vt[9]  = mk(1, c_sw, 32'h02, 32'h0, 0, 32'h0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h0, 0);
        vt[10] = mk(0, c_lw, 32'h00, 32'h0, 0, 32'h0, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 0);
        vt[11] = mk(1, c_sh, 32'h10000004, 32'h12345678, 3, 32'h0, 1, 0, 0, 1, 4'b0011, 32'h10000004, 32'h56785678, 0);
        vt[12] = mk(1, c_sb, 32'h03, 32'h0000007F, 0, 32'h0, 1, 0, 0, 1, 4'b1000, 32'h00, 32'h7F7F7F7F, 0);
        // Ack lands on the last WAIT cycle: ack must beat the timeout.
        vt[13] = mk(1, c_lw, 32'h44, 32'h0, 15, 32'hCAFEF00D, 1, 0, 0, 0, 4'b1111, 32'h44, 32'h0, 1);

        #12;
        chk("reset bus_req", 32'(bus_req), 32'd0);
        chk("reset bus_byteen", 32'(bus_byteen), 32'd0);
        chk("reset ld_type", 32'(ld_type), 32'd0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Timeout: LW never acked, ld_rdata currently CAFEF00D from the previous load.
        @(negedge clk);
        m_valid = 1'b1; m_op = c_lw; m_addr = 32'h48;
        @(posedge clk); #1;
        m_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!bus_req) break;
            cnt++;
            @(posedge clk); #1;
        end
        chk("timeout req cycles", 32'(cnt), 32'd16);
        chk("timeout bus_err", 32'(bus_err), 32'd1);
        chk("timeout ld_rdata", ld_rdata, 32'd0);
        chk("timeout ld_valid", 32'(ld_valid), 32'd0);
        chk("timeout stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("timeout bus_err one cycle", 32'(bus_err), 32'd0);

        // Back-to-back SB then LW with one IDLE gap.
        @(negedge clk);
        m_valid = 1'b1; m_op = c_sb; m_addr = 32'h01; m_wdata = 32'h5A;
        @(posedge clk); #1;
        m_op = c_lw; m_addr = 32'h04;
        chk("b2b sb byteen", 32'(bus_byteen), 32'b0010);
        @(negedge clk); bus_ack = 1'b1;
        @(posedge clk); #1; bus_ack = 1'b0;
        chk("b2b resp req", 32'(bus_req), 32'd0);
        chk("b2b resp no accept", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("b2b idle gap req", 32'(bus_req), 32'd0);
        chk("b2b idle stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        m_valid = 1'b0;
        chk("b2b lw req", 32'(bus_req), 32'd1);
        chk("b2b lw byteen", 32'(bus_byteen), 32'b1111);
        chk("b2b lw addr", bus_addr, 32'h04);
        @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h11112222;
        @(posedge clk); #1; bus_ack = 1'b0;
        chk("b2b lw ld_rdata", ld_rdata, 32'h11112222);
        @(posedge clk); #1;

        // Reset mid-WAIT, then a late ack.
        @(negedge clk);
        m_valid = 1'b1; m_op = c_lw; m_addr = 32'h80;
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst pre req", 32'(bus_req), 32'd1);
        @(negedge clk); reset = 1'b0; #1;
        chk("rst async req", 32'(bus_req), 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst ld_rdata", ld_rdata, 32'd0);
        chk("rst ld_type", 32'(ld_type), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hFEEDFACE;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late ack req", 32'(bus_req), 32'd0);
        chk("late ack ld_valid", 32'(ld_valid), 32'd0);
        chk("late ack ld_rdata", ld_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles in WAIT before abort (range 2..255).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port: m_valid  in  1  M-stage instruction valid.
REQ-005 SHALL have port: m_op  in  6  opcode: LW 100011, LH 100001, LB 100000, SW 101011, SH 101001, SB 101000; others are non-memory.
REQ-006 SHALL have ports: m_addr  in  32  byte address; m_wdata  in  32  store data (low bits used for SH/SB).
REQ-007 SHALL have ports: bus_req  out  1; bus_we  out  1; bus_addr  out  32  word-aligned; bus_byteen  out  4; bus_wdata  out  32.
REQ-008 SHALL have ports: bus_ack  in  1  transfer done; bus_rdata  in  32  valid when bus_ack=1.
REQ-009 SHALL have ports: ld_valid  out  1; ld_rdata  out  32; ld_addr10  out  2; ld_type  out  6, feeding the load-extension stage.
REQ-010 SHALL have ports: stall  out  1; exc_adel  out  1  load misaligned; exc_ades  out  1  store misaligned; bus_err  out  1  timeout.

Function
REQ-011 SHALL implement states IDLE, WAIT, RESP.
REQ-012 SHALL treat an op as accepted in IDLE when m_valid=1, m_op is a load/store, and aligned (LW/SW addr[1:0]=00; LH/SH addr[0]=0; LB/SB any).
REQ-013 SHALL on accept: IDLE->WAIT; register bus_req=1, bus_we=store, bus_addr={m_addr[31:2],2'b00}, ld_addr10=m_addr[1:0], ld_type=m_op.
REQ-014 SHALL set bus_byteen: SW 1111; SH 0011 if addr[1]=0 else 1100; SB 0001 shifted left by addr[1:0]; loads 1111.
REQ-015 SHALL set bus_wdata: SW m_wdata; SH {2{m_wdata[15:0]}}; SB {4{m_wdata[7:0]}}; loads 0.
REQ-016 SHALL hold bus_req/we/addr/byteen/wdata stable throughout WAIT until bus_ack sampled 1.
REQ-017 SHALL on bus_ack=1 in WAIT: drop bus_req next cycle, go RESP; for loads capture bus_rdata into ld_rdata and pulse ld_valid=1 during RESP.
REQ-018 SHALL count WAIT cycles; on reaching TIMEOUT without ack, drop bus_req, go RESP, ld_rdata=0, ld_valid=0, bus_err=1 for the RESP cycle.
REQ-019 SHALL give bus_ack priority over timeout when both occur in the same cycle.
REQ-020 SHALL drive stall combinationally: 1 when IDLE and accept condition true, or state=WAIT; 0 in RESP and otherwise.
REQ-021 SHALL move RESP->IDLE unconditionally after one cycle; no new accept in RESP (back-to-back ops take one IDLE cycle gap).
REQ-022 SHALL on misaligned load/store in IDLE with m_valid=1: no bus_req, stall=0, assert exc_adel (loads) or exc_ades (stores) combinationally that cycle.
REQ-023 SHALL ignore bus_ack in IDLE and RESP.
REQ-024 SHALL keep ld_rdata/ld_addr10/ld_type holding last values outside RESP.
REQ-025 SHALL do nothing (stall=0, no exc) for m_valid=0 or non-memory m_op.

Reset
REQ-026 SHALL on reset=0, immediately and regardless of state: state IDLE, counter 0, bus_req/bus_we 0, bus_addr/bus_wdata 0, bus_byteen 0000, ld_valid 0, ld_rdata 0, ld_addr10 00, ld_type 000000, bus_err 0.
REQ-027 SHALL abandon an in-flight transfer when reset asserts in WAIT (bus_req falls asynchronously); a late bus_ack after reset release SHALL be ignored.

Verification
REQ-028 SHALL cover: LB addr 0x00000013, ack after 2 cycles, rdata 0xA1B2C3D4 -> bus_addr 0x10, byteen 1111, ld_rdata 0xA1B2C3D4, ld_addr10 11, ld_type 100000, ld_valid one cycle.
REQ-029 SHALL cover: SH addr 0x22, wdata 0x0000BEEF, ack next cycle -> bus_we 1, byteen 1100, bus_wdata 0xBEEFBEEF, ld_valid stays 0.
REQ-030 SHALL cover: LW addr 0x06 -> exc_adel=1, stall=0, bus_req never asserts; SH addr 0x03 -> exc_ades=1.
REQ-031 SHALL cover: LW, ack never arrives, TIMEOUT=16 -> bus_req drops after 16 WAIT cycles, bus_err=1 one cycle, ld_rdata 0.
REQ-032 SHALL cover: SB addr 0x01 then LW addr 0x04 back-to-back -> byteen 0010 then 1111, one IDLE cycle between transfers.
REQ-033 SHALL cover: reset asserted mid-WAIT then ack -> bus_req 0 immediately, all outputs at reset values, ack ignored.
